// File: rtl/edge_detector_pkg.sv
// Shared types and size helpers for the edge-detector control path.
// Sizes are derived from the image and kernel parameters.
package edge_detector_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV,
        WRITE,
        OUT,
        DONE
    } seqState_t;

    // Number of valid kernel positions along one image axis.
    function automatic int calcOutDim(input int imgSize, input int kSize);
        return imgSize - kSize + 1;
    endfunction

    // Used for NPIX, NOUT and NTAP.
    function automatic int calcArea(input int xSize, input int ySize);
        return xSize * ySize;
    endfunction

    // Width of a counter running 0..count-1; never narrower than one bit.
    function automatic int cntWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/edge_detector_window_counter.sv
// Nested kernel-tap (kx inner, ky outer) and output-window (ox inner, oy outer) counters.
// step advances one tap; winStep advances the window once its taps have wrapped.
module edge_detector_window_counter
    import edge_detector_pkg::*;
#(
    parameter int KX_SIZE = 3,
    parameter int KY_SIZE = 3,
    parameter int OUT_X   = 98,
    parameter int OUT_Y   = 98,
    parameter int KXW     = cntWidth(KX_SIZE),
    parameter int KYW     = cntWidth(KY_SIZE),
    parameter int OXW     = cntWidth(OUT_X),
    parameter int OYW     = cntWidth(OUT_Y)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear,
    input  logic           step,
    input  logic           winStep,
    output logic [KXW-1:0] kx,
    output logic [KYW-1:0] ky,
    output logic [OXW-1:0] ox,
    output logic [OYW-1:0] oy,
    output logic           tapFirst,
    output logic           tapLast,
    output logic           winLast
);

    logic kxLast, kyLast, oxLast, oyLast;

    assign kxLast   = (kx == KXW'(KX_SIZE - 1));
    assign kyLast   = (ky == KYW'(KY_SIZE - 1));
    assign oxLast   = (ox == OXW'(OUT_X - 1));
    assign oyLast   = (oy == OYW'(OUT_Y - 1));
    assign tapFirst = (kx == '0) && (ky == '0);
    assign tapLast  = kxLast && kyLast;
    assign winLast  = oxLast && oyLast;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (clear) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else begin
            if (step) begin
                if (kxLast) begin
                    kx <= '0;
                    ky <= kyLast ? '0 : ky + 1'b1;
                end else begin
                    kx <= kx + 1'b1;
                end
            end
            // The last window wraps to (0,0) so the next frame starts clean.
            if (winStep) begin
                if (oxLast) begin
                    ox <= '0;
                    oy <= oyLast ? '0 : oy + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/edge_detector_sequencer.sv
// Frame sequencer for the edge-detection datapath: load, convolve/write, stream out.
// All strobes and addresses decode from registered state and counters.
module edge_detector_sequencer
    import edge_detector_pkg::*;
#(
    parameter int KX_SIZE    = 3,
    parameter int KY_SIZE    = 3,
    parameter int IMG_X_SIZE = 100,
    parameter int IMG_Y_SIZE = 100,
    localparam int OUT_X = calcOutDim(IMG_X_SIZE, KX_SIZE),
    localparam int OUT_Y = calcOutDim(IMG_Y_SIZE, KY_SIZE),
    localparam int NPIX  = calcArea(IMG_X_SIZE, IMG_Y_SIZE),
    localparam int NOUT  = calcArea(OUT_X, OUT_Y),
    localparam int NTAP  = calcArea(KX_SIZE, KY_SIZE),
    localparam int AW    = $clog2(NPIX),
    localparam int GW    = $clog2(NOUT),
    localparam int KW    = $clog2(NTAP)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          pixel_valid_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          memImgWr_o,
    output logic [AW-1:0] imgAddr_o,
    output logic [KW-1:0] kernelIdx_o,
    output logic          accClear_o,
    output logic          accEn_o,
    output logic          memGwr_o,
    output logic [GW-1:0] memGaddr_o,
    output logic          outValid_o,
    input  logic          outReady_i
);

    localparam int KXW = cntWidth(KX_SIZE);
    localparam int KYW = cntWidth(KY_SIZE);
    localparam int OXW = cntWidth(OUT_X);
    localparam int OYW = cntWidth(OUT_Y);

    localparam logic [AW-1:0] IMG_X_A = AW'(IMG_X_SIZE);
    localparam logic [KW-1:0] KX_K    = KW'(KX_SIZE);
    localparam logic [GW-1:0] OUT_X_G = GW'(OUT_X);

    seqState_t      state, nextState;
    logic [AW-1:0]  loadCnt;
    logic [GW-1:0]  outCnt;
    logic           frameClear, tapStep, winStep, loadInc, outInc;
    logic [KXW-1:0] kx;
    logic [KYW-1:0] ky;
    logic [OXW-1:0] ox;
    logic [OYW-1:0] oy;
    logic           tapFirst, tapLast, winLast;

    edge_detector_window_counter #(
        .KX_SIZE(KX_SIZE),
        .KY_SIZE(KY_SIZE),
        .OUT_X  (OUT_X),
        .OUT_Y  (OUT_Y),
        .KXW    (KXW),
        .KYW    (KYW),
        .OXW    (OXW),
        .OYW    (OYW)
    ) winCnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (frameClear),
        .step    (tapStep),
        .winStep (winStep),
        .kx      (kx),
        .ky      (ky),
        .ox      (ox),
        .oy      (oy),
        .tapFirst(tapFirst),
        .tapLast (tapLast),
        .winLast (winLast)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            loadCnt <= '0;
            outCnt  <= '0;
        end else begin
            state <= nextState;
            if (frameClear) begin
                loadCnt <= '0;
                outCnt  <= '0;
            end else begin
                if (loadInc) loadCnt <= loadCnt + 1'b1;
                if (outInc)  outCnt  <= outCnt + 1'b1;
            end
        end
    end

    always_comb begin
        nextState   = state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        memImgWr_o  = 1'b0;
        imgAddr_o   = '0;
        kernelIdx_o = '0;
        accClear_o  = 1'b0;
        accEn_o     = 1'b0;
        memGwr_o    = 1'b0;
        memGaddr_o  = '0;
        outValid_o  = 1'b0;
        frameClear  = 1'b0;
        tapStep     = 1'b0;
        winStep     = 1'b0;
        loadInc     = 1'b0;
        outInc      = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    frameClear = 1'b1;
                    nextState  = LOAD;
                end
            end
            LOAD: begin
                memImgWr_o = pixel_valid_i;
                imgAddr_o  = loadCnt;
                loadInc    = pixel_valid_i;
                if (pixel_valid_i && loadCnt == AW'(NPIX - 1)) nextState = CONV;
            end
            CONV: begin
                accEn_o     = 1'b1;
                accClear_o  = tapFirst;
                kernelIdx_o = KW'(ky) * KX_K + KW'(kx);
                imgAddr_o   = (AW'(oy) + AW'(ky)) * IMG_X_A + AW'(ox) + AW'(kx);
                tapStep     = 1'b1;
                if (tapLast) nextState = WRITE;
            end
            WRITE: begin
                memGwr_o   = 1'b1;
                memGaddr_o = GW'(oy) * OUT_X_G + GW'(ox);
                winStep    = 1'b1;
                nextState  = winLast ? OUT : CONV;
            end
            OUT: begin
                outValid_o = 1'b1;
                memGaddr_o = outCnt;
                outInc     = outReady_i;
                if (outReady_i && outCnt == GW'(NOUT - 1)) nextState = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_edge_detector_sequencer.sv
// Scoreboard bench for edge_detector_sequencer on a 4x4 image with a 3x3 kernel.
module tb_edge_detector_sequencer;

    localparam int KX    = 3;
    localparam int KY    = 3;
    localparam int IX    = 4;
    localparam int IY    = 4;
    localparam int OX    = IX - KX + 1;
    localparam int OY    = IY - KY + 1;
    localparam int NPIX  = IX * IY;
    localparam int NOUT  = OX * OY;
    localparam int NTAP  = KX * KY;
    localparam int FRAME = NPIX + NOUT * (NTAP + 1) + NOUT + 1;

    typedef struct {
        bit wr;
        int addr;
        int kidx;
        bit clr;
    } convEv_t;

    logic clk = 0, rst = 0, start = 0, pv = 0, ready = 0;
    logic busy, done, imgWr, accClear, accEn, gWr, outValid;
    logic [3:0] imgAddr, kIdx;
    logic [1:0] gAddr;
    logic [16:0] allOut;

    int nCmp = 0;
    int nBad = 0;
    int imgQ[$];
    int gQ[$];
    int outQ[$];
    convEv_t convQ[$];

    always #5 clk = ~clk;

    edge_detector_sequencer #(
        .KX_SIZE   (KX),
        .KY_SIZE   (KY),
        .IMG_X_SIZE(IX),
        .IMG_Y_SIZE(IY)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .pixel_valid_i(pv),
        .busy_o       (busy),
        .done_o       (done),
        .memImgWr_o   (imgWr),
        .imgAddr_o    (imgAddr),
        .kernelIdx_o  (kIdx),
        .accClear_o   (accClear),
        .accEn_o      (accEn),
        .memGwr_o     (gWr),
        .memGaddr_o   (gAddr),
        .outValid_o   (outValid),
        .outReady_i   (ready)
    );

    assign allOut = {busy, done, imgWr, imgAddr, kIdx, accClear, accEn, gWr, gAddr, outValid};

    task automatic test_reset;
        rst = 0; start = 0; pv = 0; ready = 0;
        repeat (3) @(negedge clk);
        #1;
        nCmp++;
        if (allOut !== '0) begin
            nBad++; $display("FAIL reset_hold: outputs=%h required 0", allOut);
        end
        @(negedge clk); rst = 1; start = 1;
        @(negedge clk); start = 0; pv = 1;
        #1;
        nCmp++;
        if (busy !== 1'b1 || imgWr !== 1'b1 || imgAddr !== 4'd0) begin
            nBad++; $display("FAIL reset_first_load: busy=%b wr=%b addr=%0d required 1 1 0", busy, imgWr, imgAddr);
        end
        repeat (NPIX) @(negedge clk);
        pv = 0;
        repeat (2) @(negedge clk);
        #1;
        nCmp++;
        if (accEn !== 1'b1 || kIdx !== 4'd2) begin
            nBad++; $display("FAIL reset_mid_conv: accEn=%b kIdx=%0d required 1 2", accEn, kIdx);
        end
        rst = 0;
        #1;
        nCmp++;
        if (allOut !== '0 || busy !== 1'b0) begin
            nBad++; $display("FAIL reset_async: outputs=%h required 0", allOut);
        end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_load;
        int wr = 0, c = 0, nWr = 0, e;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < NPIX; i++) imgQ.push_back(i);
        while (wr < NPIX && c < 100) begin
            if (c > 0) @(negedge clk);
            pv = (c % 2 == 0);
            #1;
            nCmp++;
            if (imgWr !== pv) begin
                nBad++; $display("FAIL load_strobe: cycle %0d wr=%b required %b", c, imgWr, pv);
            end
            if (imgWr === 1'b1) begin
                nWr++;
                e = (imgQ.size() > 0) ? imgQ.pop_front() : -1;
                nCmp++;
                if (e < 0 || imgAddr !== 4'(e)) begin
                    nBad++; $display("FAIL load_addr: addr=%0d required %0d", imgAddr, e);
                end
            end
            if (pv) wr++;
            c++;
        end
        nCmp++;
        if (nWr != NPIX || imgQ.size() != 0) begin
            nBad++; $display("FAIL load_count: writes=%0d required %0d", nWr, NPIX);
        end
    endtask

    task automatic test_conv;
        convEv_t ev;
        for (int oy = 0; oy < OY; oy++)
            for (int ox = 0; ox < OX; ox++) begin
                for (int ky = 0; ky < KY; ky++)
                    for (int kx = 0; kx < KX; kx++) begin
                        ev.wr = 0; ev.addr = (oy + ky) * IX + ox + kx;
                        ev.kidx = ky * KX + kx; ev.clr = (kx == 0 && ky == 0);
                        convQ.push_back(ev);
                    end
                ev.wr = 1; ev.addr = oy * OX + ox; ev.kidx = 0; ev.clr = 0;
                convQ.push_back(ev);
            end
        for (int c = 0; c < NOUT * (NTAP + 1); c++) begin
            @(negedge clk); pv = 0;
            #1;
            ev = convQ.pop_front();
            nCmp++;
            if (ev.wr) begin
                if (gWr !== 1'b1 || accEn !== 1'b0 || gAddr !== 2'(ev.addr)) begin
                    nBad++; $display("FAIL conv_write: cycle %0d gWr=%b accEn=%b gAddr=%0d required 1 0 %0d", c, gWr, accEn, gAddr, ev.addr);
                end
            end else if (accEn !== 1'b1 || gWr !== 1'b0 || imgAddr !== 4'(ev.addr) ||
                         kIdx !== 4'(ev.kidx) || accClear !== ev.clr) begin
                nBad++; $display("FAIL conv_tap: cycle %0d accEn=%b gWr=%b addr=%0d kIdx=%0d clr=%b required 1 0 %0d %0d %b",
                                 c, accEn, gWr, imgAddr, kIdx, accClear, ev.addr, ev.kidx, ev.clr);
            end
        end
    endtask

    task automatic test_backpressure;
        int t = 0, stall = 0, c = 0, e;
        while (t < NOUT && c < 50) begin
            @(negedge clk);
            ready = !(t == 2 && stall < 3);
            outQ.push_back(t);
            #1;
            e = outQ.pop_front();
            nCmp++;
            if (outValid !== 1'b1 || done !== 1'b0 || gAddr !== 2'(e)) begin
                nBad++; $display("FAIL out_addr: cycle %0d valid=%b done=%b gAddr=%0d required 1 0 %0d", c, outValid, done, gAddr, e);
            end
            if (ready) t++; else stall++;
            c++;
        end
        @(negedge clk); ready = 0;
        #1;
        nCmp++;
        if (done !== 1'b1 || busy !== 1'b1 || outValid !== 1'b0) begin
            nBad++; $display("FAIL out_done: done=%b busy=%b valid=%b required 1 1 0", done, busy, outValid);
        end
        @(negedge clk);
        #1;
        nCmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nBad++; $display("FAIL out_done_once: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_start_busy;
        int nWr = 0, nG = 0, nX = 0, nDone = 0, doneCyc = -1, e;
        for (int i = 0; i < NPIX; i++) imgQ.push_back(i);
        for (int i = 0; i < NOUT; i++) begin
            gQ.push_back(i);
            outQ.push_back(i);
        end
        pv = 1; ready = 1;
        for (int c = 0; c < FRAME + 8; c++) begin
            @(negedge clk);
            start = (c == 0 || c == 5 || c == FRAME - 3);
            #1;
            if (imgWr === 1'b1) begin
                nWr++;
                e = (imgQ.size() > 0) ? imgQ.pop_front() : -1;
                nCmp++;
                if (e < 0 || imgAddr !== 4'(e)) begin
                    nBad++; $display("FAIL busy_load_addr: addr=%0d required %0d", imgAddr, e);
                end
            end
            if (gWr === 1'b1) begin
                nG++;
                e = (gQ.size() > 0) ? gQ.pop_front() : -1;
                nCmp++;
                if (e < 0 || gAddr !== 2'(e)) begin
                    nBad++; $display("FAIL busy_g_addr: gAddr=%0d required %0d", gAddr, e);
                end
            end
            if (outValid === 1'b1 && ready) begin
                nX++;
                e = (outQ.size() > 0) ? outQ.pop_front() : -1;
                nCmp++;
                if (e < 0 || gAddr !== 2'(e)) begin
                    nBad++; $display("FAIL busy_out_addr: gAddr=%0d required %0d", gAddr, e);
                end
            end
            if (done === 1'b1) begin
                nDone++;
                doneCyc = c;
            end
        end
        start = 0;
        nCmp++;
        if (nWr != NPIX || nG != NOUT || nX != NOUT) begin
            nBad++; $display("FAIL busy_counts: wr=%0d g=%0d out=%0d required %0d %0d %0d", nWr, nG, nX, NPIX, NOUT, NOUT);
        end
        nCmp++;
        if (nDone != 1 || doneCyc != FRAME) begin
            nBad++; $display("FAIL busy_done: pulses=%0d at %0d required 1 at %0d", nDone, doneCyc, FRAME);
        end
    endtask

    task automatic test_back_to_back;
        int d1 = -1, d2 = -1;
        for (int c = 0; c < 2 * FRAME + 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1; pv = 1; ready = 1;
            end
            #1;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == FRAME + 1) begin
                nCmp++;
                if (busy !== 1'b0) begin
                    nBad++; $display("FAIL b2b_idle: busy=%b required 0", busy);
                end
            end
            if (c == FRAME + 2) begin
                nCmp++;
                if (imgWr !== 1'b1 || imgAddr !== 4'd0) begin
                    nBad++; $display("FAIL b2b_restart: wr=%b addr=%0d required 1 0", imgWr, imgAddr);
                end
            end
            if (c == 2 * FRAME + 1) start = 0;
        end
        nCmp++;
        if (d1 != FRAME || d2 != 2 * FRAME + 1) begin
            nBad++; $display("FAIL b2b_done: at %0d,%0d required %0d,%0d", d1, d2, FRAME, 2 * FRAME + 1);
        end
        nCmp++;
        if (busy !== 1'b0 || allOut !== '0) begin
            nBad++; $display("FAIL b2b_final_idle: outputs=%h required 0", allOut);
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_conv;
        test_backpressure;
        test_start_busy;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/edge_detector_sequencer.md
# edge_detector_sequencer

Control unit for the edge-detection datapath: it sequences a full frame through three phases (pixel load into image memory, kernel convolution into G memory, and output streaming) and generates every memory address and strobe the datapath needs. It owns all loop counters (load index, output x/y, kernel x/y, output index), so the datapath holds only memories, the accumulator and the magnitude logic. It sits directly beside the datapath inside the edge-detector top level, with the Avalon-side wrapper driving `start_i`/`pixel_valid_i` and consuming the output stream.

## Interface
- `KX_SIZE`, default 3: kernel width.
- `KY_SIZE`, default 3: kernel height.
- `IMG_X_SIZE`, default 100: image width in pixels.
- `IMG_Y_SIZE`, default 100: image height in pixels.
- Derived values: OUT_X = IMG_X_SIZE−KX_SIZE+1, OUT_Y = IMG_Y_SIZE−KY_SIZE+1, NPIX = IMG_X_SIZE·IMG_Y_SIZE, NOUT = OUT_X·OUT_Y, NTAP = KX_SIZE·KY_SIZE, AW = $clog2(NPIX), GW = $clog2(NOUT), KW = $clog2(NTAP).

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: begins a frame. Sampled only in IDLE.
- `pixel_valid_i` in 1: an input pixel is present on the datapath this cycle.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when the frame completes.
- `memImgWr_o` out 1: image-memory write strobe.
- `imgAddr_o` out AW: image-memory address, used for writes in LOAD and reads in CONV.
- `kernelIdx_o` out KW: kernel coefficient index, ky·KX_SIZE+kx.
- `accClear_o` out 1: the accumulator loads the product instead of adding it.
- `accEn_o` out 1: accumulator update enable.
- `memGwr_o` out 1: G-memory write strobe.
- `memGaddr_o` out GW: G-memory address, used for writes in WRITE and reads in OUT.
- `outValid_o` out 1: output pixel valid.
- `outReady_i` in 1: the downstream stage accepts the output pixel.

## Operation
- Both datapath memories have combinational reads, so read data is valid in the same cycle as the address.
- States: IDLE, LOAD, CONV, WRITE, OUT, DONE. State is encoded as a registered enum.
- **IDLE:** all outputs are 0.
  - `start_i`=1 clears all counters and moves to LOAD.
- **LOAD:**
  - `memImgWr_o` = `pixel_valid_i`.
  - `imgAddr_o` = loadCnt.
  - loadCnt increments on each valid pixel.
  - A valid pixel when loadCnt = NPIX−1 moves to CONV.
  - Gaps in `pixel_valid_i` are allowed and stall the load without limit.
- **CONV:** one cycle per tap.
  - `accEn_o`=1.
  - `accClear_o`=1 only on tap (0,0).
  - `kernelIdx_o` = ky·KX_SIZE+kx.
  - `imgAddr_o` = (oy+ky)·IMG_X_SIZE + (ox+kx).
  - kx is the inner loop and ky the outer loop.
  - After tap (KX−1,KY−1), move to WRITE.
- **WRITE:** one cycle.
  - `memGwr_o`=1.
  - `memGaddr_o` = oy·OUT_X+ox.
  - ox advances, wrapping to 0 and incrementing oy.
  - If (ox,oy) = (OUT_X−1,OUT_Y−1), move to OUT. Otherwise return to CONV with kx=ky=0.
- **OUT:**
  - `outValid_o`=1.
  - `memGaddr_o` = outCnt.
  - On `outValid_o`&&`outReady_i`, outCnt increments.
  - A transfer when outCnt = NOUT−1 moves to DONE.
  - While `outReady_i`=0, the address and valid are held.
- **DONE:** `done_o`=1 for one cycle, then move to IDLE.
- `start_i` is ignored outside IDLE.
- `start_i` held high continuously: a new frame starts on the cycle after DONE (IDLE is passed through in one cycle).
- Counter widths:
  - All counters saturate-free.
  - Each counter is exactly wide enough for its maximum.
  - Address arithmetic uses AW-bit unsigned math with no overflow for legal parameters.

## Timing
- Reset (`rst_i`=0, asynchronous) forces IDLE, clears all counters, and drives all outputs to 0 immediately.
- Reset mid-frame abandons the frame. The next frame starts at load address 0.
- Strobes and addresses are combinational decodes of registered state and counters. There are no input-to-output paths except `memImgWr_o` ← `pixel_valid_i`.
- Cycle counts:
  - LOAD takes NPIX valid cycles.
  - Each output pixel costs NTAP+1 cycles.
  - OUT takes at least NOUT cycles.
  - DONE takes 1 cycle.
- Defaults: 10000 load cycles, then 9604·10 = 96040 CONV/WRITE cycles, then at least 9604 OUT cycles.
- The first `accEn_o` cycle is the cycle after the last LOAD write.

## Structure
- Package `edge_detector_pkg` holds:
  - the state enum type;
  - the functions computing OUT_X, OUT_Y, NPIX, NOUT and NTAP from the parameters.
- Sub-module `edge_detector_window_counter` holds the nested kx/ky/ox/oy counters.
  - Inputs: clear, step.
  - Outputs: kx, ky, ox, oy, tapFirst, tapLast, winLast.
- The sequencer instantiates this sub-module plus the FSM and the load/output counters.

## Test plan
1. **Reset:** hold `rst_i` low, then assert it low again mid-CONV.
   - All outputs are 0 and `busy_o`=0 within the same cycle.
   - The next `start_i` rewrites from `imgAddr_o`=0.
2. **Load with gaps** (4×4 image, 3×3 kernel): 16 pixels with alternating `pixel_valid_i`.
   - Exactly 16 `memImgWr_o` pulses at addresses 0..15.
   - CONV is entered the cycle after the 16th pixel.
3. **Convolution sequence** (4×4/3×3).
   - Output 0 reads addresses 0,1,2,4,5,6,8,9,10 with `kernelIdx_o` 0..8 and `accClear_o` on the first tap, then `memGwr_o` at address 0.
   - Output 1 reads addresses 1,2,3,5,6,7,9,10,11.
   - 4 outputs take 40 cycles in total.
4. **Backpressure** (4×4/3×3): `outReady_i` low for 3 cycles at outCnt=2.
   - `memGaddr_o` is held at 2 throughout.
   - 4 transfers occur in total.
   - `done_o` pulses once, the cycle after the last transfer.
5. **Start while busy:** pulse `start_i` during LOAD and OUT.
   - No effect on the counters.
   - Exactly one `done_o` per accepted start.
6. **Default parameters:**
   - 10000 image writes.
   - 9604 `memGwr_o` pulses at addresses 0..9603, in order.
   - 9604 output transfers.
   - 115645 cycles from start to `done_o` with no stalls.
